fixedtofloat_seq_jrt: RTL and testbench

FIXEDTOFLOAT_SEQ_JRT -- requirements
Module: fixedtofloat_seq_jrt

---
 rtl/fixedtofloat_seq_jrt.sv | 134 +++++++++++++
 tb/tb_fixedtofloat_seq_jrt.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixedtofloat_seq_jrt.sv
// Fixed-point to float sequencer: hands one word at a time to an external converter
// and queues results in a first-word-fall-through FIFO. Optional macro: FIXEDTOFLOAT_SEQ_ZERO_BYPASS_EN.
//
// state      | meaning
// IDLE       | accepting an upstream word when the FIFO has room
// REQ        | one-cycle converter request pulse
// WAIT_BUSY  | waiting for the converter to raise busy
// WAIT_DONE  | waiting for busy to fall; result captured on the falling edge
// PUSH       | writing the captured result into the FIFO
module fixedtofloat_seq_jrt #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               ce,
   input  logic               i_fix_valid,
   input  logic signed [31:0] i_fix_data,
   output logic               o_fix_ready,
   output logic               o_cvt_req,
   output logic [31:0]        o_cvt_input,
   input  logic               i_cvt_busy,
   input  logic [31:0]        i_cvt_return,
   output logic               o_flt_valid,
   output logic [31:0]        o_flt_data,
   input  logic               i_flt_ready,
   output logic [4:0]         o_fifo_count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_PUSH
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     input_q, input_d;
   logic [31:0]     result_q, result_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [4:0]      count_q, count_d;
   logic [31:0]     mem [FIFO_DEPTH];

   logic            fix_ready;
   logic            take;
   logic            push;
   logic            pop;

   // Ready is gated by reset_n so it reads 0 for the whole reset window.
   assign fix_ready = reset_n && (state_q == ST_IDLE) && (count_q < 5'(FIFO_DEPTH));
   assign take      = i_fix_valid && fix_ready;
   assign push      = (state_q == ST_PUSH);
   assign pop       = (count_q != 5'd0) && i_flt_ready;

   always_comb begin
      state_d  = state_q;
      input_d  = input_q;
      result_d = result_q;
      unique case (state_q)
         ST_IDLE: begin
            if (take) begin
               input_d = i_fix_data;
`ifdef FIXEDTOFLOAT_SEQ_ZERO_BYPASS_EN
               if (i_fix_data == 32'sh0) begin
                  result_d = 32'h0;
                  state_d  = ST_PUSH;
               end else begin
                  state_d  = ST_REQ;
               end
`else
               state_d = ST_REQ;
`endif
            end
         end
         ST_REQ:       state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (i_cvt_busy) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (!i_cvt_busy) begin
               result_d = i_cvt_return;
               state_d  = ST_PUSH;
            end
         end
         ST_PUSH:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         input_q  <= '0;
         result_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (ce) begin
         state_q  <= state_d;
         input_q  <= input_d;
         result_q <= result_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the read side is masked while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (ce && push) mem[wr_ptr_q] <= result_q;
   end

   assign o_fix_ready  = fix_ready;
   assign o_cvt_req    = (state_q == ST_REQ);
   assign o_cvt_input  = input_q;
   assign o_flt_valid  = (count_q != 5'd0);
   assign o_flt_data   = o_flt_valid ? mem[rd_ptr_q] : 32'h0;
   assign o_fifo_count = count_q;

endmodule

// File: tb/tb_fixedtofloat_seq_jrt.sv
// Self-checking bench for fixedtofloat_seq_jrt: directed scenarios plus a randomized mix,
// scored against an integer-to-float reference and an ordered expectation queue.
module tb_fixedtofloat_seq_jrt;

   logic               clock = 1'b0;
   logic               reset_n = 1'b0;
   logic               ce = 1'b1;
   logic               i_fix_valid = 1'b0;
   logic signed [31:0] i_fix_data = '0;
   logic               o_fix_ready;
   logic               o_cvt_req;
   logic [31:0]        o_cvt_input;
   logic               i_cvt_busy = 1'b0;
   logic [31:0]        i_cvt_return = '0;
   logic               o_flt_valid;
   logic [31:0]        o_flt_data;
   logic               i_flt_ready = 1'b0;
   logic [4:0]         o_fifo_count;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   int          cvt_lat = 8;
   int          cvt_cnt = 0;
   int          req_cnt = 0;
   int          max_cnt = 0;
   bit          track_en = 1'b0;

   fixedtofloat_seq_jrt #(.FIFO_DEPTH(4)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .ce           (ce),
      .i_fix_valid  (i_fix_valid),
      .i_fix_data   (i_fix_data),
      .o_fix_ready  (o_fix_ready),
      .o_cvt_req    (o_cvt_req),
      .o_cvt_input  (o_cvt_input),
      .i_cvt_busy   (i_cvt_busy),
      .i_cvt_return (i_cvt_return),
      .o_flt_valid  (o_flt_valid),
      .o_flt_data   (o_flt_data),
      .i_flt_ready  (i_flt_ready),
      .o_fifo_count (o_fifo_count)
   );

   always #5 clock = ~clock;

   // Reference conversion: signed integer to single precision, truncating the mantissa.
   function automatic logic [31:0] i2f(input logic signed [31:0] x);
      logic [31:0] mag;
      logic [31:0] m;
      int          e;
      if (x == 32'sh0) return 32'h0;
      mag = x[31] ? 32'(-x) : 32'(x);
      e = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) e = i;
      m = mag << (31 - e);
      return {x[31], 8'(127 + e), m[30:8]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input string tag, input bit jitter);
      int n = 0;
      while (!o_fix_ready && n < 300) begin
         if (jitter) i_flt_ready = ($urandom_range(0, 1) == 1);
         tick();
         n++;
      end
      chk({tag, "_ready_timeout"}, 32'(o_fix_ready), 32'd1);
      i_fix_valid = 1'b1;
      i_fix_data  = d;
      tick();
      i_fix_valid = 1'b0;
   endtask

   task automatic wait_count(input int n, input int budget, input string tag);
      int k = 0;
      while (int'(o_fifo_count) != n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(o_fifo_count), 32'(n));
   endtask

   task automatic drain(input string tag);
      int k = 0;
      i_flt_ready = 1'b1;
      while ((o_fifo_count != 5'd0 || exp_q.size() != 0) && k < 400) begin
         tick();
         k++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
      i_flt_ready = 1'b0;
   endtask

   // Converter model: shares the clock enable, ignores reset_n, busy for cvt_lat cycles.
   always @(posedge clock) begin
      if (ce) begin
         if (o_cvt_req && !i_cvt_busy) begin
            i_cvt_busy   <= 1'b1;
            cvt_cnt      <= cvt_lat - 1;
            i_cvt_return <= i2f(o_cvt_input);
            req_cnt      <= req_cnt + 1;
         end else if (i_cvt_busy) begin
            if (cvt_cnt == 0) i_cvt_busy <= 1'b0;
            else              cvt_cnt    <= cvt_cnt - 1;
         end
      end
   end

   // Scoreboard: every accepted word must come out converted, in order.
   always @(posedge clock) begin
      logic [31:0] expv;
      if (!reset_n) begin
         exp_q.delete();
      end else if (ce) begin
         if (o_flt_valid && i_flt_ready) begin
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk("pop_data", o_flt_data, expv);
         end
         if (i_fix_valid && o_fix_ready) exp_q.push_back(i2f(i_fix_data));
      end
   end

   always @(negedge clock) begin
      if (!track_en)                        max_cnt = 0;
      else if (int'(o_fifo_count) > max_cnt) max_cnt = int'(o_fifo_count);
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int          r0;
      logic [31:0] a, b, z;

      // Reset values
      reset_n = 1'b0;
      tick();
      tick();
      chk("rst_fix_ready", 32'(o_fix_ready), 32'd0);
      chk("rst_cvt_req",   32'(o_cvt_req),   32'd0);
      chk("rst_cvt_input", o_cvt_input,      32'd0);
      chk("rst_flt_valid", 32'(o_flt_valid), 32'd0);
      chk("rst_flt_data",  o_flt_data,       32'd0);
      chk("rst_count",     32'(o_fifo_count), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("ready_after_rst", 32'(o_fix_ready), 32'd1);

      // Single conversion of 3 with an 8-cycle converter
      cvt_lat = 8;
      i_flt_ready = 1'b0;
      r0 = req_cnt;
      send(32'sh00000003, "single", 1'b0);
      chk("single_req_high", 32'(o_cvt_req), 32'd1);
      chk("single_cvt_input", o_cvt_input, 32'h3);
      tick();
      chk("single_req_low", 32'(o_cvt_req), 32'd0);
      n = 1;
      while (o_fifo_count == 5'd0 && n < 60) begin
         tick();
         n++;
      end
      chk("single_latency", 32'(n), 32'(cvt_lat + 3));
      chk("single_req_pulses", 32'(req_cnt - r0), 32'd1);
      chk("single_valid", 32'(o_flt_valid), 32'd1);
      chk("single_data",  o_flt_data, 32'h4040_0000);
      chk("single_count", 32'(o_fifo_count), 32'd1);
      i_flt_ready = 1'b1;
      tick();
      i_flt_ready = 1'b0;
      chk("single_popped", 32'(o_fifo_count), 32'd0);
      chk("single_empty_data", o_flt_data, 32'd0);

      // Fill the FIFO with the consumer stalled
      cvt_lat = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) send($urandom | 32'h1, "fill", 1'b0);
      wait_count(4, 60, "fill_count");
      chk("full_ready", 32'(o_fix_ready), 32'd0);
      i_fix_valid = 1'b1;
      i_fix_data  = $urandom | 32'h1;
      repeat (3) tick();
      chk("full_blocked_ready", 32'(o_fix_ready), 32'd0);
      chk("full_blocked_count", 32'(o_fifo_count), 32'd4);
      chk("full_blocked_req",   32'(o_cvt_req), 32'd0);
      i_flt_ready = 1'b1;
      tick();
      i_flt_ready = 1'b0;
      chk("after_pop_count", 32'(o_fifo_count), 32'd3);
      chk("after_pop_ready", 32'(o_fix_ready), 32'd1);
      tick();
      i_fix_valid = 1'b0;
      chk("fifth_req", 32'(o_cvt_req), 32'd1);
      drain("fill_drain");

      // Continuous stream with the consumer always ready
      track_en = 1'b1;
      cvt_lat = $urandom_range(1, 3);
      i_flt_ready = 1'b1;
      for (int i = 0; i < 6; i++) send($urandom | 32'h1, "stream", 1'b0);
      drain("stream_drain");
      chk("stream_max_count", 32'(max_cnt), 32'd1);
      track_en = 1'b0;

      // Push and pop on the same edge
      cvt_lat = 3;
      a = $urandom | 32'h1;
      b = $urandom | 32'h1;
      send(a, "pp_a", 1'b0);
      wait_count(1, 30, "pp_first");
      send(b, "pp_b", 1'b0);
      repeat (cvt_lat + 2) tick();
      chk("pp_before", 32'(o_fifo_count), 32'd1);
      i_flt_ready = 1'b1;
      tick();
      chk("pp_count_same", 32'(o_fifo_count), 32'd1);
      chk("pp_head_b", o_flt_data, i2f(b));
      tick();
      i_flt_ready = 1'b0;
      chk("pp_empty", 32'(o_fifo_count), 32'd0);

      // Reset during WAIT_DONE discards the in-flight result
      cvt_lat = 10;
      send($urandom | 32'h1, "rst_mid", 1'b0);
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      chk("rst_mid_count", 32'(o_fifo_count), 32'd0);
      chk("rst_mid_valid", 32'(o_flt_valid), 32'd0);
      chk("rst_mid_ready", 32'(o_fix_ready), 32'd0);
      tick();
      reset_n = 1'b1;
      n = 0;
      while (i_cvt_busy && n < 60) begin
         tick();
         n++;
      end
      repeat (3) tick();
      chk("rst_late_count", 32'(o_fifo_count), 32'd0);
      chk("rst_late_valid", 32'(o_flt_valid), 32'd0);
      chk("rst_late_ready", 32'(o_fix_ready), 32'd1);
      cvt_lat = 2;
      send($urandom | 32'h1, "rst_next", 1'b0);
      wait_count(1, 30, "rst_next_count");
      drain("rst_next_drain");

      // Clock enable held low while waiting for busy
      cvt_lat = 4;
      z = $urandom | 32'h1;
      send(z, "ce", 1'b0);
      tick();
      ce = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("ce_req",   32'(o_cvt_req), 32'd0);
         chk("ce_count", 32'(o_fifo_count), 32'd0);
         chk("ce_input", o_cvt_input, z);
         chk("ce_ready", 32'(o_fix_ready), 32'd0);
      end
      ce = 1'b1;
      n = 0;
      while (o_fifo_count == 5'd0 && n < 60) begin
         tick();
         n++;
      end
      chk("ce_resume_latency", 32'(n), 32'(cvt_lat + 2));
      drain("ce_drain");

      // Zero input
      cvt_lat = 3;
      r0 = req_cnt;
      send(32'h0, "zero", 1'b0);
`ifdef FIXEDTOFLOAT_SEQ_ZERO_BYPASS_EN
      chk("zero_no_req", 32'(o_cvt_req), 32'd0);
      tick();
      chk("zero_count", 32'(o_fifo_count), 32'd1);
      chk("zero_data", o_flt_data, 32'h0);
      chk("zero_req_pulses", 32'(req_cnt - r0), 32'd0);
`else
      chk("zero_req", 32'(o_cvt_req), 32'd1);
      wait_count(1, 30, "zero_count");
      chk("zero_data", o_flt_data, 32'h0);
      chk("zero_req_pulses", 32'(req_cnt - r0), 32'd1);
`endif
      drain("zero_drain");

      // Randomized mix with a jittering consumer
      for (int i = 0; i < 12; i++) begin
         cvt_lat = $urandom_range(1, 6);
         i_flt_ready = ($urandom_range(0, 1) == 1);
         send((i % 4 == 3) ? 32'(-int'($urandom_range(1, 100000))) : $urandom, "mix", 1'b1);
      end
      drain("mix_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
